// File: rtl/alu_8bit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_8bit_if
// Description : Operand/opcode and result/flag bundle for alu_8bit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_8bit_if;
   logic [7:0] operand1;
   logic [7:0] operand2;
   logic [2:0] aluop;
   logic [7:0] aluresult;
   logic       zero;
   logic       carry;

   // Decode/register-file side: drives operands, observes results.
   modport master (
      output operand1,
      output operand2,
      output aluop,
      input  aluresult,
      input  zero,
      input  carry
   );

   // ALU side.
   modport slave (
      input  operand1,
      input  operand2,
      input  aluop,
      output aluresult,
      output zero,
      output carry
   );
endinterface
`default_nettype wire

// File: rtl/alu_8bit.sv
`default_nettype none
// ============================================================================
// Module      : alu_8bit
// Description : Registered 8-bit ALU (FORWARD/ADD/AND/OR) with ZERO/CARRY.
//               Define ALU_EXT_OPS_EN to add SUB/XOR/SLL/SRL on 3'b100-3'b111.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8bit (
   input  logic      clk,
   input  logic      rst_n,
   alu_8bit_if.slave bus
);

   localparam logic [2:0] c_op_fwd = 3'b000;
   localparam logic [2:0] c_op_add = 3'b001;
   localparam logic [2:0] c_op_and = 3'b010;
   localparam logic [2:0] c_op_or  = 3'b011;
`ifdef ALU_EXT_OPS_EN
   localparam logic [2:0] c_op_sub = 3'b100;
   localparam logic [2:0] c_op_xor = 3'b101;
   localparam logic [2:0] c_op_sll = 3'b110;
   localparam logic [2:0] c_op_srl = 3'b111;
`endif

   logic [7:0] r_result;
   logic       r_zero;
   logic       r_carry;

   logic [7:0] w_result;
   logic       w_carry;
   logic [8:0] w_sum9;
`ifdef ALU_EXT_OPS_EN
   logic [8:0]  w_diff9;
   logic [2:0]  w_shamt;
   logic [15:0] w_sll16;
   logic [15:0] w_srl16;
`endif

   assign w_sum9 = {1'b0, bus.operand1} + {1'b0, bus.operand2};

`ifdef ALU_EXT_OPS_EN
   // Widened shifts land the last bit shifted out at a fixed position
   // (bit 8 for left, bit 7 for right); a zero shift leaves a 0 there.
   assign w_diff9 = {1'b0, bus.operand1} - {1'b0, bus.operand2};
   assign w_shamt = bus.operand2[2:0];
   assign w_sll16 = {8'h00, bus.operand1} << w_shamt;
   assign w_srl16 = {bus.operand1, 8'h00} >> w_shamt;
`endif

   // Unknown or unsupported opcodes fall to the default and yield 0x00/0.
   always_comb begin
      w_result = 8'h00;
      w_carry  = 1'b0;
      case (bus.aluop)
         c_op_fwd: w_result = bus.operand2;
         c_op_add: begin
            w_result = w_sum9[7:0];
            w_carry  = w_sum9[8];
         end
         c_op_and: w_result = bus.operand1 & bus.operand2;
         c_op_or:  w_result = bus.operand1 | bus.operand2;
`ifdef ALU_EXT_OPS_EN
         c_op_sub: begin
            w_result = w_diff9[7:0];
            w_carry  = w_diff9[8];
         end
         c_op_xor: w_result = bus.operand1 ^ bus.operand2;
         c_op_sll: begin
            w_result = w_sll16[7:0];
            w_carry  = w_sll16[8];
         end
         c_op_srl: begin
            w_result = w_srl16[15:8];
            w_carry  = w_srl16[7];
         end
`endif
         default: begin
            w_result = 8'h00;
            w_carry  = 1'b0;
         end
      endcase
   end

   // ZERO is taken from the same-cycle result so it never lags ALURESULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= 8'h00;
         r_zero   <= 1'b1;
         r_carry  <= 1'b0;
      end else begin
         r_result <= w_result;
         r_zero   <= (w_result == 8'h00);
         r_carry  <= w_carry;
      end
   end

   assign bus.aluresult = r_result;
   assign bus.zero      = r_zero;
   assign bus.carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_8bit
// Description : Directed self-checking bench for alu_8bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8bit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_8bit_if bus ();

   alu_8bit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] res,
                            input logic z, input logic c);
      check({tag, ".result"}, bus.aluresult, res);
      check({tag, ".zero"},   {7'd0, bus.zero},  {7'd0, z});
      check({tag, ".carry"},  {7'd0, bus.carry}, {7'd0, c});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.operand1 = a;
      bus.operand2 = b;
      bus.aluop    = op;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(8'h00, 8'h55, 3'b000);

      // Edges during reset are ignored.
      tick();
      tick();
      check_out("reset_hold", 8'h00, 1'b1, 1'b0);

      rst_n = 1'b1;
      tick();
      check_out("first_edge_fwd", 8'h55, 1'b0, 1'b0);

      // Asynchronous clear between edges, pending work discarded.
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 8'h00, 1'b1, 1'b0);
      drive(8'd200, 8'd100, 3'b001);
      tick();
      tick();
      check_out("reset_ignores_clk", 8'h00, 1'b1, 1'b0);
      rst_n = 1'b1;

      drive(8'd10, 8'd20, 3'b000);
      tick();
      check_out("fwd", 8'd20, 1'b0, 1'b0);
      drive(8'd10, 8'd15, 3'b001);
      #2;
      check("add_before_edge", bus.aluresult, 8'd20);
      tick();
      check_out("add", 8'd25, 1'b0, 1'b0);

      drive(8'd7, 8'd14, 3'b010);
      tick();
      check_out("and", 8'd6, 1'b0, 1'b0);
      drive(8'd7, 8'd30, 3'b011);
      #2;
      check("or_before_edge", bus.aluresult, 8'd6);
      tick();
      check_out("or", 8'd31, 1'b0, 1'b0);

      drive(8'd200, 8'd100, 3'b001);
      tick();
      check_out("add_wrap", 8'd44, 1'b0, 1'b1);
      drive(8'd128, 8'd128, 3'b001);
      tick();
      check_out("add_wrap_zero", 8'd0, 1'b1, 1'b1);

      // Mid-cycle input change must not disturb registered outputs.
      drive(8'd1, 8'd2, 3'b001);
      #3;
      check_out("hold", 8'd0, 1'b1, 1'b1);
      tick();
      check_out("add_small", 8'd3, 1'b0, 1'b0);

      drive(8'hFF, 8'h00, 3'b010);
      tick();
      check_out("and_zero", 8'h00, 1'b1, 1'b0);

`ifdef ALU_EXT_OPS_EN
      drive(8'd5, 8'd7, 3'b100);
      tick();
      check_out("sub_borrow", 8'd254, 1'b0, 1'b1);
      drive(8'd7, 8'd5, 3'b100);
      tick();
      check_out("sub", 8'd2, 1'b0, 1'b0);
      drive(8'hF0, 8'hFF, 3'b101);
      tick();
      check_out("xor", 8'h0F, 1'b0, 1'b0);
      drive(8'h81, 8'd1, 3'b110);
      tick();
      check_out("sll1", 8'h02, 1'b0, 1'b1);
      drive(8'h81, 8'd0, 3'b110);
      tick();
      check_out("sll0", 8'h81, 1'b0, 1'b0);
      drive(8'h81, 8'd1, 3'b111);
      tick();
      check_out("srl1", 8'h40, 1'b0, 1'b1);
      drive(8'h81, 8'hF7, 3'b111);
      tick();
      check_out("srl7", 8'h01, 1'b0, 1'b0);
`else
      drive(8'd200, 8'd100, 3'b001);
      tick();
      check_out("pre_ext", 8'd44, 1'b0, 1'b1);
      drive(8'd5, 8'd7, 3'b100);
      tick();
      check_out("op100_disabled", 8'h00, 1'b1, 1'b0);
      drive(8'hF0, 8'h0F, 3'b111);
      tick();
      check_out("op111_disabled", 8'h00, 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
